// File: rtl/lmu_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lmu_ram_arbiter
// Purpose  : Shares one single-port 32-bit LMU SRAM among N_PORTS OBI-style
//            requesters. Fair round-robin arbitration (at most one RAM access
//            per cycle) plus a READ_LAT-deep response pipeline that routes
//            each response (read data or write ack) back to its issuing port.
// Ports    : clk_i, rst_ni          clock, asynchronous active-low reset
//            m_req_i/m_we_i         per-port request / write enable
//            m_addr_i/m_wdata_i/m_be_i  packed per-port address, data, strobes
//            m_gnt_o                one-hot grant, same cycle as the request
//            m_rvalid_o             per-port response valid
//            m_rdata_o              shared response data (RAM data passthrough)
//            ram_*                  single-port SRAM interface
//            conflict_cnt_o/access_cnt_o  saturating counters (optional)
// Options  : LMU_ARB_PERF_EN        adds the two performance counter outputs
// Revision : 1.0  initial release
// ============================================================================
module lmu_ram_arbiter #(
    parameter int  NUM_WORDS = 1024,
    parameter int  N_PORTS   = 2,
    parameter int  READ_LAT  = 1,
    localparam int AW        = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_PORTS-1:0]    m_req_i,
    input  logic [N_PORTS-1:0]    m_we_i,
    input  logic [N_PORTS*AW-1:0] m_addr_i,
    input  logic [N_PORTS*32-1:0] m_wdata_i,
    input  logic [N_PORTS*4-1:0]  m_be_i,
    output logic [N_PORTS-1:0]    m_gnt_o,
    output logic [N_PORTS-1:0]    m_rvalid_o,
    output logic [31:0]           m_rdata_o,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [AW-1:0]         ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i
`ifdef LMU_ARB_PERF_EN
    ,
    output logic [31:0]           conflict_cnt_o,
    output logic [31:0]           access_cnt_o
`endif
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      w_cand;
    logic [PW-1:0]      w_sel;
    logic [PW-1:0]      w_ptr_nxt;
    logic               w_found;
    logic [N_PORTS-1:0] w_gnt;
    logic               w_we;
    logic [AW-1:0]      w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic [READ_LAT-1:0] r_vld;
    logic [PW-1:0]      r_pid [READ_LAT];
    logic [N_PORTS-1:0] w_rvalid;

    // Round-robin search starting at the pointer. Candidates are reduced
    // modulo N_PORTS, so indices beyond the last port can never be chosen.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_cand = PW'((int'(r_ptr) + i) % N_PORTS);
            if (!w_found && m_req_i[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_found) begin
            w_gnt[w_sel] = 1'b1;
        end
    end

    // Forward the granted port's access; everything reads 0 without a grant.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        if (w_found) begin
            w_we    = m_we_i[w_sel];
            w_addr  = m_addr_i[int'(w_sel)*AW +: AW];
            w_wdata = m_wdata_i[int'(w_sel)*32 +: 32];
            w_be    = m_be_i[int'(w_sel)*4 +: 4];
        end
    end

    assign w_ptr_nxt = (w_sel == PW'(N_PORTS - 1)) ? '0 : (w_sel + PW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Response pipeline: one {valid, port} entry per granted access, reads
    // and writes alike, so responses come back in grant order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_pid[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_found;
            r_pid[0] <= w_sel;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_pid[i] <= r_pid[i-1];
            end
        end
    end

    always_comb begin
        w_rvalid = '0;
        if (r_vld[READ_LAT-1]) begin
            w_rvalid[r_pid[READ_LAT-1]] = 1'b1;
        end
    end

    assign m_gnt_o     = w_gnt;
    assign m_rvalid_o  = w_rvalid;
    assign m_rdata_o   = ram_rdata_i;
    assign ram_req_o   = |m_req_i;
    assign ram_we_o    = w_we;
    assign ram_addr_o  = w_addr;
    assign ram_wdata_o = w_wdata;
    assign ram_be_o    = w_be;

`ifdef LMU_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_access_cnt;
    logic        w_conflict;

    assign w_conflict = ($countones(m_req_i) > 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_conflict_cnt <= '0;
            r_access_cnt   <= '0;
        end else begin
            if (w_conflict && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
            if (w_found && (r_access_cnt != '1)) begin
                r_access_cnt <= r_access_cnt + 32'd1;
            end
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
    assign access_cnt_o   = r_access_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lmu_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lmu_ram_arbiter
// Purpose  : Self-checking bench. Instance A: 2 ports, READ_LAT=1.
//            Instance B: 3 ports, READ_LAT=2. Each drives a behavioural SRAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_lmu_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-instance stimulus arrays: [instance][port]
    logic        req_s  [2][3];
    logic        we_s   [2][3];
    logic [9:0]  addr_s [2][3];
    logic [31:0] wd_s   [2][3];
    logic [3:0]  be_s   [2][3];

    logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
    logic [19:0] a_addr;
    logic [63:0] a_wdata;
    logic [7:0]  a_be;
    logic [31:0] a_rdata, a_ram_wdata, a_ram_rdata, a_rd1;
    logic        a_ram_req, a_ram_we;
    logic [9:0]  a_ram_addr;
    logic [3:0]  a_ram_be;

    logic [2:0]  b_req, b_we, b_gnt, b_rvalid;
    logic [29:0] b_addr;
    logic [95:0] b_wdata;
    logic [11:0] b_be;
    logic [31:0] b_rdata, b_ram_wdata, b_ram_rdata, b_rd1, b_rd2;
    logic        b_ram_req, b_ram_we;
    logic [9:0]  b_ram_addr;
    logic [3:0]  b_ram_be;

`ifdef LMU_ARB_PERF_EN
    logic [31:0] a_conf, a_acc, b_conf, b_acc;
`endif

    assign a_req   = {req_s[0][1], req_s[0][0]};
    assign a_we    = {we_s[0][1], we_s[0][0]};
    assign a_addr  = {addr_s[0][1], addr_s[0][0]};
    assign a_wdata = {wd_s[0][1], wd_s[0][0]};
    assign a_be    = {be_s[0][1], be_s[0][0]};
    assign b_req   = {req_s[1][2], req_s[1][1], req_s[1][0]};
    assign b_we    = {we_s[1][2], we_s[1][1], we_s[1][0]};
    assign b_addr  = {addr_s[1][2], addr_s[1][1], addr_s[1][0]};
    assign b_wdata = {wd_s[1][2], wd_s[1][1], wd_s[1][0]};
    assign b_be    = {be_s[1][2], be_s[1][1], be_s[1][0]};

    // Uniform views of both instances' outputs
    logic [2:0]  gnt_v [2];
    logic [2:0]  rv_v  [2];
    logic        ramreq_v [2];
    logic        ramwe_v  [2];
    logic [9:0]  ramaddr_v [2];
    logic [31:0] ramwd_v [2];
    logic [31:0] rdata_v [2];
    logic [3:0]  rambe_v [2];

    assign gnt_v[0] = {1'b0, a_gnt};    assign gnt_v[1] = b_gnt;
    assign rv_v[0]  = {1'b0, a_rvalid}; assign rv_v[1]  = b_rvalid;
    assign ramreq_v[0] = a_ram_req;     assign ramreq_v[1] = b_ram_req;
    assign ramwe_v[0]  = a_ram_we;      assign ramwe_v[1]  = b_ram_we;
    assign ramaddr_v[0] = a_ram_addr;   assign ramaddr_v[1] = b_ram_addr;
    assign ramwd_v[0] = a_ram_wdata;    assign ramwd_v[1] = b_ram_wdata;
    assign rambe_v[0] = a_ram_be;       assign rambe_v[1] = b_ram_be;
    assign rdata_v[0] = a_rdata;        assign rdata_v[1] = b_rdata;

    lmu_ram_arbiter #(.NUM_WORDS(1024), .N_PORTS(2), .READ_LAT(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(a_req), .m_we_i(a_we), .m_addr_i(a_addr),
        .m_wdata_i(a_wdata), .m_be_i(a_be),
        .m_gnt_o(a_gnt), .m_rvalid_o(a_rvalid), .m_rdata_o(a_rdata),
        .ram_req_o(a_ram_req), .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr),
        .ram_wdata_o(a_ram_wdata), .ram_be_o(a_ram_be), .ram_rdata_i(a_ram_rdata)
`ifdef LMU_ARB_PERF_EN
        , .conflict_cnt_o(a_conf), .access_cnt_o(a_acc)
`endif
    );

    lmu_ram_arbiter #(.NUM_WORDS(1024), .N_PORTS(3), .READ_LAT(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(b_req), .m_we_i(b_we), .m_addr_i(b_addr),
        .m_wdata_i(b_wdata), .m_be_i(b_be),
        .m_gnt_o(b_gnt), .m_rvalid_o(b_rvalid), .m_rdata_o(b_rdata),
        .ram_req_o(b_ram_req), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr),
        .ram_wdata_o(b_ram_wdata), .ram_be_o(b_ram_be), .ram_rdata_i(b_ram_rdata)
`ifdef LMU_ARB_PERF_EN
        , .conflict_cnt_o(b_conf), .access_cnt_o(b_acc)
`endif
    );

    // Behavioural single-port SRAMs with 1- and 2-cycle read latency
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    always @(posedge clk) begin
        if (a_ram_req) begin
            if (a_ram_we) begin
                for (int j = 0; j < 4; j++)
                    if (a_ram_be[j]) mem_a[a_ram_addr][8*j +: 8] <= a_ram_wdata[8*j +: 8];
            end else begin
                a_rd1 <= mem_a[a_ram_addr];
            end
        end
    end
    assign a_ram_rdata = a_rd1;

    always @(posedge clk) begin
        b_rd2 <= b_rd1;
        if (b_ram_req) begin
            if (b_ram_we) begin
                for (int j = 0; j < 4; j++)
                    if (b_ram_be[j]) mem_b[b_ram_addr][8*j +: 8] <= b_ram_wdata[8*j +: 8];
            end else begin
                b_rd1 <= mem_b[b_ram_addr];
            end
        end
    end
    assign b_ram_rdata = b_rd2;

    // ---------------------------------------------------------------- helpers
    task automatic clear_inputs();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                req_s[d][k] = 1'b0; we_s[d][k] = 1'b0; addr_s[d][k] = '0;
                wd_s[d][k] = '0; be_s[d][k] = '0;
            end
    endtask

    task automatic set_port(input int d, input int k, input logic we,
                            input logic [9:0] a, input logic [31:0] wd, input logic [3:0] be);
        req_s[d][k] = 1'b1; we_s[d][k] = we; addr_s[d][k] = a;
        wd_s[d][k] = wd; be_s[d][k] = be;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({gnt_v[d], rv_v[d], ramreq_v[d], ramwe_v[d], ramaddr_v[d], ramwd_v[d], rambe_v[d]} !== 54'd0) begin
                errors++;
                $display("FAIL reset_in dut%0d: gnt=%b rvalid=%b ram_req=%b expected all 0",
                         d, gnt_v[d], rv_v[d], ramreq_v[d]);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({gnt_v[d], rv_v[d], ramreq_v[d], ramwe_v[d], ramaddr_v[d], ramwd_v[d], rambe_v[d]} !== 54'd0) begin
                    errors++;
                    $display("FAIL idle dut%0d cyc%0d: gnt=%b rvalid=%b ram_req=%b expected all 0",
                             d, c, gnt_v[d], rv_v[d], ramreq_v[d]);
                end
            end
        end
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        set_port(0, 0, 1'b1, 10'd5, 32'hCAFEBABE, 4'hF);
        #1;
        checks++;
        if (gnt_v[0] !== 3'b001 || ramwe_v[0] !== 1'b1 || ramaddr_v[0] !== 10'd5) begin
            errors++;
            $display("FAIL single_wr: gnt=%b we=%b addr=%0d expected 001 1 5", gnt_v[0], ramwe_v[0], ramaddr_v[0]);
        end
        @(negedge clk);
        clear_inputs();
        set_port(0, 1, 1'b0, 10'd5, 32'h0, 4'h0);
        #1;
        checks++;
        if (gnt_v[0] !== 3'b010) begin
            errors++;
            $display("FAIL single_rd_gnt: gnt=%b expected 010", gnt_v[0]);
        end
        checks++;
        if (rv_v[0] !== 3'b001) begin
            errors++;
            $display("FAIL single_wr_ack: rvalid=%b expected 001", rv_v[0]);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (rv_v[0] !== 3'b010 || rdata_v[0] !== 32'hCAFEBABE) begin
            errors++;
            $display("FAIL single_rd_rsp: rvalid=%b rdata=%h expected 010 cafebabe", rv_v[0], rdata_v[0]);
        end
    endtask

    task automatic test_contention();
        logic [2:0] eg, er;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clear_inputs();
            if (i < 6) begin
                set_port(0, 0, 1'b0, 10'($urandom_range(0, 15)), 32'h0, 4'h0);
                set_port(0, 1, 1'b0, 10'($urandom_range(0, 15)), 32'h0, 4'h0);
            end
            #1;
            eg = (i >= 6) ? 3'b000 : ((i % 2 == 1) ? 3'b010 : 3'b001);
            er = (i == 0) ? 3'b000 : (((i - 1) % 2 == 1) ? 3'b010 : 3'b001);
            checks++;
            if (gnt_v[0] !== eg) begin
                errors++;
                $display("FAIL contention_gnt cyc%0d: gnt=%b expected %b", i, gnt_v[0], eg);
            end
            checks++;
            if (rv_v[0] !== er) begin
                errors++;
                $display("FAIL contention_rvalid cyc%0d: rvalid=%b expected %b", i, rv_v[0], er);
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_back_to_back_lat2();
        logic [31:0] dv [3];
        logic [2:0]  er;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            clear_inputs();
            dv[j] = $urandom;
            set_port(1, 0, 1'b1, 10'(j), dv[j], 4'hF);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            clear_inputs();
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clear_inputs();
            if (i < 3) set_port(1, 0, 1'b0, 10'(i), 32'h0, 4'h0);
            #1;
            if (i < 3) begin
                checks++;
                if (gnt_v[1] !== 3'b001) begin
                    errors++;
                    $display("FAIL lat2_gnt cyc%0d: gnt=%b expected 001", i, gnt_v[1]);
                end
            end
            er = (i >= 2 && i <= 4) ? 3'b001 : 3'b000;
            checks++;
            if (rv_v[1] !== er) begin
                errors++;
                $display("FAIL lat2_rvalid cyc%0d: rvalid=%b expected %b", i, rv_v[1], er);
            end
            if (i >= 2 && i <= 4) begin
                checks++;
                if (rdata_v[1] !== dv[i-2]) begin
                    errors++;
                    $display("FAIL lat2_rdata cyc%0d: rdata=%h expected %h", i, rdata_v[1], dv[i-2]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        @(negedge clk);
        clear_inputs();
        set_port(1, 1, 1'b0, 10'd7, 32'h0, 4'h0);
        #1;
        checks++;
        if (gnt_v[1] !== 3'b010) begin
            errors++;
            $display("FAIL midflight_gnt: gnt=%b expected 010", gnt_v[1]);
        end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rv_v[1] !== 3'b000) begin
            errors++;
            $display("FAIL midflight_in_reset: rvalid=%b expected 000", rv_v[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            checks++;
            if (rv_v[1] !== 3'b000) begin
                errors++;
                $display("FAIL midflight_no_rsp cyc%0d: rvalid=%b expected 000", c, rv_v[1]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) set_port(1, k, 1'b0, 10'd0, 32'h0, 4'h0);
        #1;
        checks++;
        if (gnt_v[1] !== 3'b001) begin
            errors++;
            $display("FAIL midflight_ptr: gnt=%b expected 001", gnt_v[1]);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    // Random traffic against a transaction-level model: grant choice from a
    // rotating priority index, responses scheduled at grant cycle + latency.
    int          q_due  [$];
    int          q_port [$];
    bit          q_rd   [$];
    logic [31:0] q_data [$];

    task automatic test_random(input int d);
        int np, lat, ptr, cyc, g;
        logic [31:0] shadow [16];
        bit          hold [3];
        logic [2:0]  eg, er;
        logic [46:0] eram;
        np  = (d == 0) ? 2 : 3;
        lat = (d == 0) ? 1 : 2;
        q_due.delete(); q_port.delete(); q_rd.delete(); q_data.delete();
        // Fill the address window so every read has a known value
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            clear_inputs();
            shadow[a] = $urandom;
            set_port(d, 0, 1'b1, 10'(a), shadow[a], 4'hF);
        end
        do_reset();
        ptr = 0;
        cyc = 0;
        for (int k = 0; k < 3; k++) hold[k] = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            for (int k = 0; k < np; k++) begin
                if (n >= 196) begin
                    req_s[d][k] = 1'b0;
                end else if (!hold[k]) begin
                    req_s[d][k]  = ($urandom_range(0, 3) != 0);
                    we_s[d][k]   = 1'($urandom_range(0, 1));
                    addr_s[d][k] = 10'($urandom_range(0, 15));
                    wd_s[d][k]   = $urandom;
                    be_s[d][k]   = 4'($urandom_range(0, 15));
                end
            end
            #1;
            g = -1;
            for (int i = 0; i < np; i++) begin
                int k;
                k = (ptr + i) % np;
                if (g < 0 && req_s[d][k]) g = k;
            end
            eg = 3'b000;
            eram = '0;
            if (g >= 0) begin
                eg[g] = 1'b1;
                eram = {we_s[d][g], addr_s[d][g], wd_s[d][g], be_s[d][g]};
            end
            checks++;
            if (gnt_v[d] !== eg) begin
                errors++;
                $display("FAIL rand_gnt dut%0d cyc%0d: gnt=%b expected %b", d, cyc, gnt_v[d], eg);
            end
            checks++;
            if ({ramwe_v[d], ramaddr_v[d], ramwd_v[d], rambe_v[d]} !== eram || ramreq_v[d] !== (g >= 0)) begin
                errors++;
                $display("FAIL rand_ram dut%0d cyc%0d: req=%b bus=%h expected req=%b bus=%h",
                         d, cyc, ramreq_v[d], {ramwe_v[d], ramaddr_v[d], ramwd_v[d], rambe_v[d]}, g >= 0, eram);
            end
            er = 3'b000;
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                er[q_port[0]] = 1'b1;
                if (q_rd[0]) begin
                    checks++;
                    if (rdata_v[d] !== q_data[0]) begin
                        errors++;
                        $display("FAIL rand_rdata dut%0d cyc%0d: rdata=%h expected %h", d, cyc, rdata_v[d], q_data[0]);
                    end
                end
                void'(q_due.pop_front()); void'(q_port.pop_front());
                void'(q_rd.pop_front());  void'(q_data.pop_front());
            end
            checks++;
            if (rv_v[d] !== er) begin
                errors++;
                $display("FAIL rand_rvalid dut%0d cyc%0d: rvalid=%b expected %b", d, cyc, rv_v[d], er);
            end
            if (g >= 0) begin
                q_due.push_back(cyc + lat);
                q_port.push_back(g);
                q_rd.push_back(!we_s[d][g]);
                q_data.push_back(shadow[addr_s[d][g][3:0]]);
                if (we_s[d][g])
                    for (int j = 0; j < 4; j++)
                        if (be_s[d][g][j]) shadow[addr_s[d][g][3:0]][8*j +: 8] = wd_s[d][g][8*j +: 8];
                ptr = (g + 1) % np;
            end
            for (int k = 0; k < np; k++) hold[k] = req_s[d][k] && (k != g);
            cyc++;
        end
        @(negedge clk);
        clear_inputs();
    endtask

`ifdef LMU_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_inputs();
            set_port(0, 0, 1'b0, 10'd0, 32'h0, 4'h0);
            if (i < 4) set_port(0, 1, 1'b0, 10'd1, 32'h0, 4'h0);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (a_conf !== 32'd4 || a_acc !== 32'd6) begin
            errors++;
            $display("FAIL perf: conflict=%0d access=%0d expected 4 6", a_conf, a_acc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back_lat2();
        test_reset_midflight();
        test_random(0);
        test_random(1);
`ifdef LMU_ARB_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
